ov5640_sccb_cfg: RTL

OV5640_SCCB_CFG -- requirements
Module: ov5640_sccb_cfg

---
 rtl/ov5640_sccb_cfg.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/ov5640_sccb_cfg.sv
// ov5640_sccb_cfg: walks an external register table and writes each entry to an
// OV5640 over SCCB as a 3-phase write (device address, 16-bit register
// address, data byte), after a power-up delay.
// Optional feature macro: SCCB_ACK_CHECK_EN. When it is defined, a NACK aborts
// the transaction after its STOP and retries the same index, up to 3 retries.
// A 4th NACK sets cfg_err_o. When it is undefined, ACK is ignored.
// Bus outputs are registered so SCL/SDA never glitch. They therefore trail the
// internal quarter sequence by one cycle.
module ov5640_sccb_cfg #(
  parameter int unsigned CLK_DIV  = 250,
  parameter int unsigned REG_NUM  = 252,
  parameter logic [7:0]  DEV_ADDR = 8'h78,
  parameter logic [19:0] PWR_DLY  = 20'd100000
) (
  input  logic        cmos_clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  output logic [7:0]  cfg_idx_o,
  input  logic [23:0] cfg_data_i,
  output logic        sccb_scl_o,
  output logic        sccb_sda_o,
  output logic        sccb_sda_oe_o,
  input  logic        sccb_sda_i,
  output logic        cfg_busy_o,
  output logic        cfg_done_o,
  output logic        cfg_err_o
);

  localparam int unsigned QW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);
  localparam logic [7:0] IDX_LAST  = 8'(REG_NUM - 1);
  localparam logic [19:0] DLY_LAST = PWR_DLY - 20'd1;

  typedef enum logic [2:0] {
    S_IDLE, S_PWR_WAIT, S_LOAD, S_START, S_BYTE, S_STOP, S_GAP, S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [19:0]   r_dly;
  logic [QW-1:0] r_qcnt;
  logic [1:0]    r_q;
  logic [3:0]    r_bit;
  logic [1:0]    r_byte;
  logic [31:0]   r_shift;
  logic [7:0]    r_idx;
  logic          r_scl;
  logic          r_sda;
  logic          r_oe;

  logic w_qend;
  logic w_pend;
  logic w_last_bit;
  logic w_bus_state;
  logic w_start_ok;
  logic w_nack;
  logic w_retry_left;
  logic w_scl;
  logic w_sda;
  logic w_oe;

  assign w_qend      = (r_qcnt == Q_LAST);
  assign w_pend      = w_qend && (r_q == 2'd3);
  assign w_last_bit  = (r_bit == 4'd8);
  assign w_bus_state = (r_state == S_START) || (r_state == S_BYTE) ||
                       (r_state == S_STOP)  || (r_state == S_GAP);
  assign w_start_ok  = start_i && ((r_state == S_IDLE) || (r_state == S_DONE));

`ifdef SCCB_ACK_CHECK_EN
  logic       r_nack;
  logic [1:0] r_retry;
  logic       r_err;

  assign w_nack       = r_nack;
  assign w_retry_left = (r_retry != 2'd3);
  assign cfg_err_o    = r_err;

  // ACK sampling, retry count and sticky error flag
  always_ff @(posedge cmos_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_nack  <= 1'b0;
      r_retry <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_retry <= '0;
        r_err   <= 1'b0;
      end else if ((r_state == S_STOP) && w_pend && r_nack) begin
        if (r_retry == 2'd3) r_err <= 1'b1;
        else                 r_retry <= r_retry + 2'd1;
      end else if ((r_state == S_GAP) && w_pend) begin
        r_retry <= '0;
      end
      if (r_state == S_LOAD)
        r_nack <= 1'b0;
      else if ((r_state == S_BYTE) && w_last_bit && (r_q == 2'd2) && w_qend)
        r_nack <= sccb_sda_i;
    end
  end
`else
  logic w_unused_sda;
  assign w_unused_sda = sccb_sda_i;
  assign w_nack       = 1'b0;
  assign w_retry_left = 1'b1;
  assign cfg_err_o    = 1'b0;
`endif

  // State register
  always_ff @(posedge cmos_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; every bus phase ends on the last cycle of its 4th quarter
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start_i) w_state_nxt = S_PWR_WAIT;
      S_PWR_WAIT:     if (r_dly == DLY_LAST) w_state_nxt = S_LOAD;
      S_LOAD:         w_state_nxt = S_START;
      S_START:        if (w_pend) w_state_nxt = S_BYTE;
      S_BYTE: begin
        // a NACK skips the remaining bytes and goes straight to STOP
        if (w_pend && w_last_bit && ((r_byte == 2'd3) || w_nack))
          w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_pend) begin
          if (w_nack) w_state_nxt = w_retry_left ? S_LOAD : S_DONE;
          else        w_state_nxt = S_GAP;
        end
      end
      S_GAP: if (w_pend) w_state_nxt = (r_idx == IDX_LAST) ? S_DONE : S_LOAD;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus levels for the current quarter, before the output register
  always_comb begin
    w_scl = 1'b1;
    w_sda = 1'b1;
    w_oe  = 1'b0;
    case (r_state)
      S_START: begin
        w_oe  = 1'b1;
        w_scl = (r_q != 2'd3);
        w_sda = (r_q == 2'd0);
      end
      S_BYTE: begin
        w_scl = (r_q == 2'd1) || (r_q == 2'd2);
        if (!w_last_bit) begin
          w_oe  = 1'b1;
          w_sda = r_shift[31];
        end
      end
      S_STOP: begin
        w_oe  = 1'b1;
        w_scl = (r_q != 2'd0);
        w_sda = r_q[1];
      end
      default: ;
    endcase
  end

  // Counters, shift register and table index
  always_ff @(posedge cmos_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_dly   <= '0;
      r_qcnt  <= '0;
      r_q     <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_shift <= '0;
      r_idx   <= '0;
    end else begin
      r_dly <= (r_state == S_PWR_WAIT) ? r_dly + 20'd1 : '0;
      if (w_bus_state) begin
        r_qcnt <= w_qend ? '0 : r_qcnt + QW'(1);
        if (w_qend) r_q <= r_q + 2'd1;
      end else begin
        r_qcnt <= '0;
        r_q    <= '0;
      end
      if (r_state == S_LOAD) begin
        r_shift <= {DEV_ADDR, cfg_data_i};
        r_bit   <= '0;
        r_byte  <= '0;
      end else if ((r_state == S_BYTE) && w_pend) begin
        if (w_last_bit) begin
          r_bit  <= '0;
          r_byte <= r_byte + 2'd1;
        end else begin
          r_bit   <= r_bit + 4'd1;
          r_shift <= {r_shift[30:0], 1'b0};
        end
      end
      if (w_start_ok)
        r_idx <= '0;
      else if ((r_state == S_GAP) && w_pend && (r_idx != IDX_LAST))
        r_idx <= r_idx + 8'd1;
    end
  end

  // Registered bus outputs; reset drives an idle, released bus
  always_ff @(posedge cmos_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_scl <= 1'b1;
      r_sda <= 1'b1;
      r_oe  <= 1'b0;
    end else begin
      r_scl <= w_scl;
      r_sda <= w_sda;
      r_oe  <= w_oe;
    end
  end

  assign sccb_scl_o    = r_scl;
  assign sccb_sda_o    = r_sda;
  assign sccb_sda_oe_o = r_oe;
  assign cfg_idx_o     = r_idx;
  assign cfg_busy_o    = (r_state != S_IDLE) && (r_state != S_DONE);
  assign cfg_done_o    = (r_state == S_DONE);

endmodule
